fb_write_ctrl: RTL and testbench
================================

# fb_write_ctrl

Write-port controller for the 640x480 1-bit-per-pixel framebuffer RAM. It shares the single RAM write port between two sources: a drawing engine, which issues pixel plots and horizontal spans through a valid/ready handshake, and a full-screen clear sequencer. It converts (x, y) coordinates to linear addresses (y*640 + x) and drives registered `ram_we`, `ram_addr` and `ram_din` into the framebuffer. The VGA read side is untouched.

## Interface
- `H_RES`, 640, pixels per line
- `V_RES`, 480, lines per frame
- `ADDR_W`, 19, RAM address width (H_RES*V_RES = 307200 needs 19 bits)

- `Clk`  in  1  system clock (MAX10_CLK1_50)
- `Reset`  in  1  asynchronous, active-high reset
- `clear_req`  in  1  single-cycle pulse; requests a full-screen fill
- `clear_val`  in  1  fill value, sampled with `clear_req`
- `req_valid`  in  1  draw request valid
- `req_ready`  out  1  draw request accepted when `req_valid` and `req_ready` are both high
- `req_span`  in  1  0 = plot one pixel, 1 = horizontal span
- `req_x0`, `req_x1`  in  10 each  start and end x (inclusive); `req_x1` is ignored for plots
- `req_y`  in  10  line
- `req_color`  in  1  pixel value
- `busy`  out  1  high whenever state is not IDLE
- `done`  out  1  one-cycle pulse when an operation completes
- `ram_we`, `ram_din`  out  1 each  RAM write enable and write data (registered)
- `ram_addr`  out  ADDR_W  RAM write address (registered)

## Operation
- States: IDLE, PLOT, SPAN, CLEAR.
- `req_ready` = (state == IDLE) && !clear_pend.
- `clear_req` sets `clear_pend` and latches `clear_val`.
  - If `clear_req` arrives while in CLEAR, it is ignored.
  - If it arrives during PLOT or SPAN, it stays pending; the current operation finishes first.
- Transitions out of IDLE:
  - If `clear_pend`: go to CLEAR, with counter = 0 and `clear_pend` cleared. A clear wins over a simultaneous `req_valid`, which is not accepted.
  - Else, on handshake: go to PLOT or SPAN. Capture x0, x1, y and color.
- PLOT: one write at y*H_RES + x0, then back to IDLE.
- SPAN:
  - Effective end = min(x1, H_RES-1).
  - If the end is less than x0, only x0 is written.
  - Writes proceed at consecutive addresses, one per cycle, from x0 through the end, then back to IDLE.
- CLEAR: writes `clear_val` to addresses 0 .. H_RES*V_RES-1, one per cycle, then back to IDLE.
- Clipping: if a request has x0 >= H_RES or y >= V_RES, the handshake completes but nothing is written. The FSM passes through PLOT/SPAN for 1 cycle with `ram_we` = 0, and `done` still pulses.
- Address arithmetic:
  - Row base y*H_RES is computed once at accept, at ADDR_W width.
  - The span/clear counter increments the address; a multiply per pixel is not allowed.

## Timing
- Reset values:
  - State = IDLE, `clear_pend` = 0.
  - `ram_we` = 0, `ram_addr` = 0, `ram_din` = 0, `busy` = 0, `done` = 0.
  - `req_ready` = 1.
- Reset mid-operation aborts immediately. No further writes occur and no `done` pulse is emitted.
- Handshake accepted at edge N: the first `ram_we` = 1 is visible in cycle N+1. `busy` = 1 from N+1.
- PLOT: 1 write cycle. SPAN: (end - x0 + 1) write cycles. CLEAR: 307200 write cycles.
- `done` pulses in the cycle after the last write. In that same cycle state = IDLE and `req_ready` may already be 1 (back-to-back: a new accept at that edge is allowed).
- `ram_we` is never high for more than one address per cycle. Addresses are strictly increasing within an operation.

## Configuration
- `FB_SPAN_EN` defined: SPAN state and the `req_x1` path are compiled in, as described above.
- `FB_SPAN_EN` undefined: SPAN is removed and `req_span` is ignored. Every request is a PLOT at x0, and `req_x1` is unused.

## Test plan
- Reset, then `req_valid` with x0=5, y=2, color=1, span=0 -> one cycle of `ram_we` = 1 with addr=1285 and din=1, at N+1. `done` at N+2.
- Span x0=630, x1=700, y=0, color=1 -> 10 writes at addr 630..639, then `done`. With `FB_SPAN_EN` undefined -> a single write at 630.
- `clear_req`, `clear_val`=0 -> 307200 writes at addr 0..307199 with din=0. `req_ready` = 0 throughout. `done` one cycle after addr 307199.
- `clear_req` pulsed mid-span (x0=0, x1=99) -> the span completes all 100 writes, then CLEAR starts with no IDLE accept in between.
- Request with x0=640, y=10 -> accepted, no `ram_we`, `done` pulses.
- Assert `Reset` at clear address 1000 -> all outputs 0 asynchronously. After release: IDLE, `req_ready` = 1, no pending clear.

Source files
------------

// File: rtl/fb_write_ctrl_if.sv
// fb_write_ctrl_if -- draw-request channel between a drawing engine and the
// framebuffer write controller.
//
// Signals:
//   req_valid  engine -> ctrl  request valid
//   req_ready  ctrl -> engine  controller can accept (transfer when both high)
//   req_span   engine -> ctrl  0 = single pixel, 1 = horizontal span
//   req_x0     engine -> ctrl  start x (inclusive)
//   req_x1     engine -> ctrl  end x (inclusive), span only
//   req_y      engine -> ctrl  line
//   req_color  engine -> ctrl  pixel value
//
// Modports: master = drawing engine, slave = write controller.
interface fb_write_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_span;
  logic [9:0] req_x0;
  logic [9:0] req_x1;
  logic [9:0] req_y;
  logic       req_color;

  modport master (
    output req_valid, req_span, req_x0, req_x1, req_y, req_color,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_span, req_x0, req_x1, req_y, req_color,
    output req_ready
  );
endinterface

// File: rtl/fb_write_ctrl.sv
// fb_write_ctrl -- single write port arbiter for the 1-bpp framebuffer.
// Shares the RAM write port between draw requests (pixel plots and horizontal
// spans) and a full-screen clear sequencer. (x, y) is turned into the linear
// address y*H_RES + x once per request; consecutive pixels are reached by
// incrementing the address.
//
// Build option: define FB_SPAN_EN to compile in the SPAN state and the req_x1
// path. Without it every request is written as a single pixel at req_x0.
//
// Ports:
//   Clk        system clock
//   Reset      asynchronous, active-high reset
//   clear_req  one-cycle pulse requesting a full-screen fill
//   clear_val  fill value, sampled together with clear_req
//   draw       draw-request channel (fb_write_ctrl_if.slave)
//   busy       high whenever the FSM is not idle
//   done       one-cycle pulse after the last write of an operation
//   ram_we     RAM write enable (registered)
//   ram_din    RAM write data (registered)
//   ram_addr   RAM write address (registered)
module fb_write_ctrl #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clear_req,
  input  logic              clear_val,
  fb_write_ctrl_if.slave    draw,
  output logic              busy,
  output logic              done,
  output logic              ram_we,
  output logic              ram_din,
  output logic [ADDR_W-1:0] ram_addr
);

  localparam logic [9:0]        X_LIM     = 10'(H_RES);
  localparam logic [9:0]        Y_LIM     = 10'(V_RES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  typedef enum logic [1:0] {IDLE, PLOT, SPAN, CLEAR} state_t;

  state_t            state_reg, state_next;
  logic              clear_pend_reg, clear_pend_next;
  logic              clear_val_reg, clear_val_next;
  logic              ram_we_reg, ram_we_next;
  logic              ram_din_reg, ram_din_next;
  logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
  logic              done_reg, done_next;
  logic              start_clear;

  // Off-screen requests still handshake and pass through PLOT/SPAN for one
  // cycle, they just never raise the write enable.
  logic              clipped;
  logic [ADDR_W-1:0] pix_addr;

  assign clipped  = (draw.req_x0 >= X_LIM) || (draw.req_y >= Y_LIM);
  assign pix_addr = ADDR_W'(draw.req_y) * ADDR_W'(H_RES) + ADDR_W'(draw.req_x0);

`ifdef FB_SPAN_EN
  localparam logic [9:0] X_MAX = 10'(H_RES - 1);
  logic [9:0] x_reg, x_next;
  logic [9:0] end_reg, end_next;
  logic [9:0] x1_sat, span_end;

  // A reversed or clipped span degenerates to the single start pixel, so
  // the SPAN state always exits once x reaches end.
  assign x1_sat   = (draw.req_x1 > X_MAX) ? X_MAX : draw.req_x1;
  assign span_end = (clipped || (x1_sat < draw.req_x0)) ? draw.req_x0 : x1_sat;
`else
  logic unused_span_inputs;
  assign unused_span_inputs = ^{draw.req_span, draw.req_x1};
`endif

  assign draw.req_ready = (state_reg == IDLE) && !clear_pend_reg;
  assign busy           = (state_reg != IDLE);
  assign done           = done_reg;
  assign ram_we         = ram_we_reg;
  assign ram_din        = ram_din_reg;
  assign ram_addr       = ram_addr_reg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg      <= IDLE;
      clear_pend_reg <= 1'b0;
      clear_val_reg  <= 1'b0;
      ram_we_reg     <= 1'b0;
      ram_din_reg    <= 1'b0;
      ram_addr_reg   <= '0;
      done_reg       <= 1'b0;
`ifdef FB_SPAN_EN
      x_reg          <= '0;
      end_reg        <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      clear_pend_reg <= clear_pend_next;
      clear_val_reg  <= clear_val_next;
      ram_we_reg     <= ram_we_next;
      ram_din_reg    <= ram_din_next;
      ram_addr_reg   <= ram_addr_next;
      done_reg       <= done_next;
`ifdef FB_SPAN_EN
      x_reg          <= x_next;
      end_reg        <= end_next;
`endif
    end
  end

  // The RAM outputs are loaded at the accept edge itself, so the first write
  // is already on the port in the first cycle of PLOT/SPAN/CLEAR.
  always_comb begin
    state_next      = state_reg;
    clear_pend_next = clear_pend_reg;
    clear_val_next  = clear_val_reg;
    ram_we_next     = 1'b0;
    ram_din_next    = ram_din_reg;
    ram_addr_next   = ram_addr_reg;
    done_next       = 1'b0;
    start_clear     = 1'b0;
`ifdef FB_SPAN_EN
    x_next          = x_reg;
    end_next        = end_reg;
`endif

    unique case (state_reg)
      IDLE: begin
        if (clear_pend_reg) begin
          start_clear     = 1'b1;
          state_next      = CLEAR;
          clear_pend_next = 1'b0;
          ram_we_next     = 1'b1;
          ram_addr_next   = '0;
          ram_din_next    = clear_val_reg;
        end else if (draw.req_valid) begin
          ram_we_next   = !clipped;
          ram_addr_next = pix_addr;
          ram_din_next  = draw.req_color;
          state_next    = PLOT;
`ifdef FB_SPAN_EN
          x_next   = draw.req_x0;
          end_next = span_end;
          if (draw.req_span) state_next = SPAN;
`endif
        end
      end
      PLOT: begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
`ifdef FB_SPAN_EN
      SPAN: begin
        if (x_reg == end_reg) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          x_next        = x_reg + 10'd1;
          ram_addr_next = ram_addr_reg + 1'b1;
          ram_we_next   = 1'b1;
        end
      end
`endif
      CLEAR: begin
        if (ram_addr_reg == LAST_ADDR) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          ram_addr_next = ram_addr_reg + 1'b1;
          ram_we_next   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // A request arriving while a clear runs (or is just starting) folds into it.
    if (clear_req && (state_reg != CLEAR) && !start_clear) begin
      clear_pend_next = 1'b1;
      clear_val_next  = clear_val;
    end
  end

endmodule

// File: tb/tb_fb_write_ctrl.sv
module tb_fb_write_ctrl;

  localparam int H_RES  = 640;
  localparam int V_RES  = 8;    // short frame keeps the clear sweep brief
  localparam int ADDR_W = 19;
  localparam int NPIX   = H_RES * V_RES;

`ifdef FB_SPAN_EN
  localparam bit SPAN_ON = 1'b1;
`else
  localparam bit SPAN_ON = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              clear_req = 1'b0;
  logic              clear_val = 1'b0;
  logic              busy, done, ram_we, ram_din;
  logic [ADDR_W-1:0] ram_addr;

  fb_write_ctrl_if draw ();

  fb_write_ctrl #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Reset(Reset), .clear_req(clear_req), .clear_val(clear_val),
    .draw(draw), .busy(busy), .done(done), .ram_we(ram_we),
    .ram_din(ram_din), .ram_addr(ram_addr)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct {
    bit span;
    int x0, x1, y;
    bit color;
    int exp_addr;      // first written address
    int cnt_span;      // writes with spans compiled in
    int cnt_plot;      // writes with spans compiled out
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input int idx, input vec_t v);
    int exp_cnt, cnt, first_addr, first_idx, prev_addr, done_idx, wc;
    bit seq_ok, din_ok;
    exp_cnt = SPAN_ON ? v.cnt_span : v.cnt_plot;
    @(negedge Clk);
    draw.req_valid = 1'b1;
    draw.req_span  = v.span;
    draw.req_x0    = 10'(v.x0);
    draw.req_x1    = 10'(v.x1);
    draw.req_y     = 10'(v.y);
    draw.req_color = v.color;
    wc = 0;
    while (!draw.req_ready && wc < 50) begin @(negedge Clk); wc++; end
    chk($sformatf("v%0d_ready", idx), int'(draw.req_ready), 1);
    @(negedge Clk);                       // cycle N+1
    draw.req_valid = 1'b0;
    chk($sformatf("v%0d_busy", idx), int'(busy), 1);
    cnt = 0; first_addr = -1; first_idx = -1; prev_addr = -1; done_idx = -1;
    seq_ok = 1'b1; din_ok = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      if (done) begin done_idx = c; break; end
      if (ram_we) begin
        if (cnt == 0) begin first_addr = int'(ram_addr); first_idx = c; end
        else if (int'(ram_addr) != prev_addr + 1) seq_ok = 1'b0;
        if (ram_din != v.color) din_ok = 1'b0;
        prev_addr = int'(ram_addr);
        cnt++;
      end
      @(negedge Clk);
    end
    chk($sformatf("v%0d_count", idx), cnt, exp_cnt);
    if (exp_cnt > 0) begin
      chk($sformatf("v%0d_first_addr", idx), first_addr, v.exp_addr);
      chk($sformatf("v%0d_first_cycle", idx), first_idx, 0);
      chk($sformatf("v%0d_seq", idx), int'(seq_ok), 1);
      chk($sformatf("v%0d_din", idx), int'(din_ok), 1);
    end
    chk($sformatf("v%0d_done_cycle", idx), done_idx, (exp_cnt > 0) ? exp_cnt : 1);
    chk($sformatf("v%0d_idle_at_done", idx), int'(busy), 0);
    $display("vec %0d: span=%0d x0=%0d x1=%0d y=%0d -> writes=%0d first=%0d done@%0d",
             idx, v.span, v.x0, v.x1, v.y, cnt, first_addr, done_idx);
  endtask

  initial begin
    int cnt, last_addr, first_addr, done_idx, last_idx, wc;
    bit seq_ok, din_ok, rdy_low;

    //            span  x0   x1   y   col addr  span plot
    vecs[0] = '{1'b0,   5,   0,  2, 1'b1, 1285,  1, 1};
    vecs[1] = '{1'b1, 630, 700,  0, 1'b1,  630, 10, 1};
    vecs[2] = '{1'b1,  10,   3,  1, 1'b0,  650,  1, 1};
    vecs[3] = '{1'b0, 639,   0,  7, 1'b1, 5119,  1, 1};
    vecs[4] = '{1'b0, 640,   0,  2, 1'b1,    0,  0, 0};
    vecs[5] = '{1'b1,   5,  20, 10, 1'b1,    0,  0, 0};
    vecs[6] = '{1'b1, 100, 103,  3, 1'b0, 2020,  4, 1};
    vecs[7] = '{1'b0,   0,  50,  0, 1'b1,    0,  1, 1};
    vecs[8] = '{1'b1, 639, 639,  1, 1'b1, 1279,  1, 1};

    draw.req_valid = 1'b0; draw.req_span = 1'b0; draw.req_x0 = '0;
    draw.req_x1 = '0; draw.req_y = '0; draw.req_color = 1'b0;

    // Reset values
    repeat (3) @(negedge Clk);
    chk("rst_we", int'(ram_we), 0);
    chk("rst_addr", int'(ram_addr), 0);
    chk("rst_din", int'(ram_din), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(draw.req_ready), 1);
    Reset = 1'b0;
    $display("reset released");

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Full clear with fill value 1
    @(negedge Clk);
    clear_req = 1'b1; clear_val = 1'b1;
    @(negedge Clk);
    clear_req = 1'b0;
    chk("clr_ready_pend", int'(draw.req_ready), 0);
    @(negedge Clk);
    cnt = 0; first_addr = -1; last_addr = -1; done_idx = -1; last_idx = -1;
    seq_ok = 1'b1; din_ok = 1'b1; rdy_low = 1'b1;
    for (int c = 0; c < NPIX + 100; c++) begin
      if (done) begin done_idx = c; break; end
      if (draw.req_ready) rdy_low = 1'b0;
      if (ram_we) begin
        if (cnt == 0) first_addr = int'(ram_addr);
        else if (int'(ram_addr) != last_addr + 1) seq_ok = 1'b0;
        if (ram_din != 1'b1) din_ok = 1'b0;
        last_addr = int'(ram_addr);
        last_idx = c;
        cnt++;
      end
      @(negedge Clk);
    end
    chk("clr_count", cnt, NPIX);
    chk("clr_first", first_addr, 0);
    chk("clr_last", last_addr, NPIX - 1);
    chk("clr_seq", int'(seq_ok), 1);
    chk("clr_din", int'(din_ok), 1);
    chk("clr_ready_low", int'(rdy_low), 1);
    chk("clr_done_cycle", done_idx, last_idx + 1);
    $display("clear: writes=%0d first=%0d last=%0d done@%0d", cnt, first_addr, last_addr, done_idx);

    // Clear pulsed during a span: span completes, then clear starts directly
    @(negedge Clk);
    draw.req_valid = 1'b1; draw.req_span = 1'b1; draw.req_x0 = 10'd0;
    draw.req_x1 = 10'd99; draw.req_y = 10'd0; draw.req_color = 1'b1;
    wc = 0;
    while (!draw.req_ready && wc < 50) begin @(negedge Clk); wc++; end
    @(negedge Clk);                       // cycle N+1: first span write
    draw.req_valid = 1'b0;
    cnt = ram_we ? 1 : 0;
    clear_req = 1'b1; clear_val = 1'b0;
    @(negedge Clk);
    clear_req = 1'b0;
    done_idx = -1;
    for (int c = 0; c < 300; c++) begin
      if (done) begin done_idx = c; break; end
      if (ram_we) cnt++;
      @(negedge Clk);
    end
    chk("mid_span_count", cnt, SPAN_ON ? 100 : 1);
    chk("mid_done_seen", int'(done_idx >= 0), 1);
    chk("mid_ready_at_done", int'(draw.req_ready), 0);
    @(negedge Clk);
    chk("mid_clr_we", int'(ram_we), 1);
    chk("mid_clr_addr", int'(ram_addr), 0);
    chk("mid_clr_din", int'(ram_din), 0);
    chk("mid_clr_busy", int'(busy), 1);
    $display("mid-span clear: span writes=%0d, clear started at addr %0d", cnt, ram_addr);

    // Asynchronous reset at clear address 1000
    wc = 0;
    while (!(ram_we && ram_addr == ADDR_W'(1000)) && wc < 2000) begin @(negedge Clk); wc++; end
    chk("abort_reached_1000", int'(ram_addr), 1000);
    Reset = 1'b1;
    #1;
    chk("abort_we", int'(ram_we), 0);
    chk("abort_addr", int'(ram_addr), 0);
    chk("abort_din", int'(ram_din), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    @(negedge Clk);
    Reset = 1'b0;
    cnt = 0; wc = 0;
    for (int c = 0; c < 10; c++) begin
      if (ram_we) cnt++;
      if (done || busy) wc++;
      @(negedge Clk);
    end
    chk("post_abort_writes", cnt, 0);
    chk("post_abort_activity", wc, 0);
    chk("post_abort_ready", int'(draw.req_ready), 1);
    $display("reset abort: writes after release=%0d", cnt);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
